xbus_ctrl: RTL and testbench
============================

# xbus_ctrl

External bus controller and arbiter for the MCU51 core's multiplexed P0/P2 memory bus. Two requesters share the single bus: the instruction fetch path (CODE space, PSEN) and the MOVX path (XDATA space, RD/WR). The block grants one requester at a time and sequences each access as address phase, ALE latch, strobe and data phase. It sits between the CU/PC fetch logic and the port pins, and owns ALE, PSEN_n, RD_n, WR_n and the P0/P2 bus drivers during external accesses.

## Interface
- T_STROBE, 2, base strobe-low length in clk cycles (1..15)
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  reset, synchronous, active-high
- fetch_req  in  1  fetch request; level, held until fetch_ack
- fetch_addr  in  16  code address
- fetch_ack  out  1  one-cycle completion pulse
- fetch_data  out  8  code byte; valid from the fetch_ack cycle until the next fetch completes
- movx_req  in  1  MOVX request; level, held until movx_ack
- movx_we  in  1  1 = write (WR_n), 0 = read (RD_n)
- movx_addr  in  16  XDATA address
- movx_wdata  in  8  write data
- movx_ack  out  1  one-cycle completion pulse
- movx_rdata  out  8  read data; valid from the movx_ack cycle until the next MOVX read completes
- wait_cycles  in  2  extra strobe cycles, 0..3 (present only with XBUS_WAIT_EN)
- ale  out  1  address latch enable, active-high
- psen_n, rd_n, wr_n  out  1 each  strobes, active-low
- p0_out  out  8  P0 drive value (low address / write data)
- p0_oe  out  1  P0 output enable
- p0_in  in  8  P0 pin value
- p2_out  out  8  high address
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, ADDR, HOLD, STROBE, END.
- IDLE: strobes high, ale 0, p0_oe 0. If any eligible request is pending, register the winner, its address, we and wdata (and wait_cycles) and go to ADDR.
- ADDR (1 cycle): ale 1, p0_out = addr[7:0], p0_oe 1, p2_out = addr[15:8].
- HOLD (1 cycle): ale 0, address still driven on P0 and P2.
- STROBE (T_STROBE + wait cycles):
  - Fetch: psen_n 0, p0_oe 0.
  - MOVX read: rd_n 0, p0_oe 0.
  - MOVX write: wr_n 0, p0_out = wdata, p0_oe 1.
  - Reads sample p0_in into the requester's data register on the rising edge that ends the last STROBE cycle.
- END (1 cycle): all strobes high, ack of the served requester = 1.
  - Write: p0_oe stays 1 with wdata (hold).
  - Read: p0_oe 0.
  - Next state: ADDR if the other requester is pending (granted here), else IDLE.
- Eligibility: the requester being acked in END is not eligible in that cycle. This prevents serving one request twice.
- Arbitration, both pending: the requester not granted last wins. last_grant resets to MOVX, so fetch wins the first contention.
- Address, we and wdata are captured at grant. Requester inputs may change after grant without affecting the access.
- Request dropped before grant: no access. Request dropped after grant: the access completes and ack still pulses.
- p2_out holds its last value in IDLE.

## Timing
- Reset values: ale 0, psen_n/rd_n/wr_n 1, p0_oe 0, p0_out 0x00, p2_out 0x00, acks 0, fetch_data/movx_rdata 0x00, busy 0, state IDLE, last_grant MOVX.
- Reset asserted mid-access: all outputs take their reset values on the next edge. No ack is generated and the access is abandoned.
- Latency: request high in IDLE at edge k gives ADDR in cycle k+1 and ack in cycle k+3+T_STROBE+W, where W is the wait count (0 without the macro). With the default T_STROBE, ack arrives 5 cycles after the request.
- Back-to-back, alternating requesters: one access every 3+T_STROBE+W cycles, because END overlaps the arbitration cycle.
- The same requester re-requesting passes through IDLE, adding 1 cycle.
- ale is high for exactly one cycle per access. Strobes never overlap: at most one of psen_n/rd_n/wr_n is low.

## Configuration
- XBUS_WAIT_EN defined:
  - wait_cycles port exists and is sampled at grant.
  - STROBE length = T_STROBE + wait_cycles.
- Undefined:
  - Port is absent.
  - STROBE length = T_STROBE.

## Test plan
- Fetch read: fetch_req=1, fetch_addr=0x1234, p0_in=0xA5 during strobe -> ale pulse with p0_out=0x34 and p2_out=0x12, psen_n low for 2 cycles, fetch_ack 5 cycles after the request, fetch_data=0xA5.
- MOVX write: movx_we=1, addr 0x8001, wdata 0x3C -> p0_out=0x3C with p0_oe=1 and wr_n low for 2 cycles; rd_n and psen_n stay 1; movx_ack once.
- Contention: both requests raised in the same cycle out of reset -> fetch served first, MOVX granted in the fetch END cycle, second ack 5 cycles after the first.
- Reset asserted in the second STROBE cycle of a MOVX read -> next edge shows rd_n=1, p0_oe=0, no movx_ack, movx_rdata=0x00.
- XBUS_WAIT_EN with wait_cycles=3 on a fetch -> psen_n low 5 cycles, ack 8 cycles after the request.
- Request pulsed for 1 cycle while busy with the other requester -> no access and no ack for the pulsed requester.

Source files
------------

// File: rtl/xbus_ctrl.sv
// External P0/P2 bus controller arbitrating instruction fetch (PSEN) and MOVX (RD/WR) accesses.
// Define XBUS_WAIT_EN to add the wait_cycles port, which stretches STROBE by 0..3 cycles.
//
// state  | meaning
// IDLE   | bus released, arbitrate pending requests
// ADDR   | ale high, address on P0/P2
// HOLD   | ale low, address held for the external latch
// STROBE | psen_n/rd_n/wr_n low for the strobe length
// END    | strobes released, ack pulse, arbitrate the other requester
module xbus_ctrl #(
    parameter int unsigned T_STROBE = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_req,
    input  logic [15:0] fetch_addr,
    output logic        fetch_ack,
    output logic [7:0]  fetch_data,
    input  logic        movx_req,
    input  logic        movx_we,
    input  logic [15:0] movx_addr,
    input  logic [7:0]  movx_wdata,
    output logic        movx_ack,
    output logic [7:0]  movx_rdata,
`ifdef XBUS_WAIT_EN
    input  logic [1:0]  wait_cycles,
`endif
    output logic        ale,
    output logic        psen_n,
    output logic        rd_n,
    output logic        wr_n,
    output logic [7:0]  p0_out,
    output logic        p0_oe,
    input  logic [7:0]  p0_in,
    output logic [7:0]  p2_out,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_HOLD,
        S_STROBE,
        S_END
    } state_t;

    localparam int CW = 5;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic           cur_fetch;
    logic           cur_we;
    logic [7:0]     cur_wdata;
    logic [1:0]     cur_wait;
    logic           last_fetch;

    logic [1:0]     wait_in;
    logic [CW-1:0]  strobe_len;
    logic           fetch_elig;
    logic           movx_elig;
    logic           pick_fetch;
    logic           any_elig;
    logic [15:0]    grant_addr;

`ifdef XBUS_WAIT_EN
    assign wait_in = wait_cycles;
`else
    assign wait_in = 2'd0;
`endif

    assign strobe_len = CW'(T_STROBE) + {3'b000, cur_wait};

    // The requester being acked in END must not be re-granted in that same cycle.
    always_comb begin
        fetch_elig = fetch_req && !(state == S_END && cur_fetch);
        movx_elig  = movx_req  && !(state == S_END && !cur_fetch);
        pick_fetch = fetch_elig && (!movx_elig || !last_fetch);
        any_elig   = fetch_elig || movx_elig;
        grant_addr = pick_fetch ? fetch_addr : movx_addr;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            cur_fetch  <= 1'b0;
            cur_we     <= 1'b0;
            cur_wdata  <= 8'h00;
            cur_wait   <= 2'd0;
            last_fetch <= 1'b0;
            fetch_ack  <= 1'b0;
            movx_ack   <= 1'b0;
            fetch_data <= 8'h00;
            movx_rdata <= 8'h00;
            ale        <= 1'b0;
            psen_n     <= 1'b1;
            rd_n       <= 1'b1;
            wr_n       <= 1'b1;
            p0_out     <= 8'h00;
            p0_oe      <= 1'b0;
            p2_out     <= 8'h00;
            busy       <= 1'b0;
        end else begin
            fetch_ack <= 1'b0;
            movx_ack  <= 1'b0;
            case (state)
                S_IDLE, S_END: begin
                    psen_n <= 1'b1;
                    rd_n   <= 1'b1;
                    wr_n   <= 1'b1;
                    if (any_elig) begin
                        state      <= S_ADDR;
                        busy       <= 1'b1;
                        ale        <= 1'b1;
                        p0_out     <= grant_addr[7:0];
                        p2_out     <= grant_addr[15:8];
                        p0_oe      <= 1'b1;
                        cur_fetch  <= pick_fetch;
                        cur_we     <= !pick_fetch && movx_we;
                        cur_wdata  <= movx_wdata;
                        cur_wait   <= wait_in;
                        last_fetch <= pick_fetch;
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        ale   <= 1'b0;
                        p0_oe <= 1'b0;
                    end
                end
                S_ADDR: begin
                    ale   <= 1'b0;
                    state <= S_HOLD;
                end
                S_HOLD: begin
                    state <= S_STROBE;
                    cnt   <= strobe_len - CW'(1);
                    if (cur_fetch) begin
                        psen_n <= 1'b0;
                        p0_oe  <= 1'b0;
                    end else if (cur_we) begin
                        wr_n   <= 1'b0;
                        p0_out <= cur_wdata;
                        p0_oe  <= 1'b1;
                    end else begin
                        rd_n  <= 1'b0;
                        p0_oe <= 1'b0;
                    end
                end
                S_STROBE: begin
                    if (cnt == '0) begin
                        state  <= S_END;
                        psen_n <= 1'b1;
                        rd_n   <= 1'b1;
                        wr_n   <= 1'b1;
                        // Write data stays driven through END as hold time.
                        if (!cur_we) begin
                            p0_oe <= 1'b0;
                        end
                        if (cur_fetch) begin
                            fetch_ack  <= 1'b1;
                            fetch_data <= p0_in;
                        end else begin
                            movx_ack <= 1'b1;
                            if (!cur_we) begin
                                movx_rdata <= p0_in;
                            end
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xbus_ctrl.sv
// Directed bench for xbus_ctrl: fetch, MOVX read/write, arbitration, reset abort, request pulses.
module tb_xbus_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_req;
    logic [15:0] fetch_addr;
    logic        fetch_ack;
    logic [7:0]  fetch_data;
    logic        movx_req;
    logic        movx_we;
    logic [15:0] movx_addr;
    logic [7:0]  movx_wdata;
    logic        movx_ack;
    logic [7:0]  movx_rdata;
`ifdef XBUS_WAIT_EN
    logic [1:0]  wait_cycles;
`endif
    logic        ale;
    logic        psen_n;
    logic        rd_n;
    logic        wr_n;
    logic [7:0]  p0_out;
    logic        p0_oe;
    logic [7:0]  p0_in;
    logic [7:0]  p2_out;
    logic        busy;

    always #5 clk = ~clk;

    xbus_ctrl #(.T_STROBE(2)) dut (
        .clk(clk), .reset(reset),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_ack(fetch_ack), .fetch_data(fetch_data),
        .movx_req(movx_req), .movx_we(movx_we), .movx_addr(movx_addr),
        .movx_wdata(movx_wdata), .movx_ack(movx_ack), .movx_rdata(movx_rdata),
`ifdef XBUS_WAIT_EN
        .wait_cycles(wait_cycles),
`endif
        .ale(ale), .psen_n(psen_n), .rd_n(rd_n), .wr_n(wr_n),
        .p0_out(p0_out), .p0_oe(p0_oe), .p0_in(p0_in),
        .p2_out(p2_out), .busy(busy)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc, ale_cnt, psen_lo, rd_lo, wr_lo, overlap, wr_bad;
    int fack_cnt, mack_cnt, fack_first, mack_first, fack_last;
    logic [7:0] ale_p0, ale_p2, code_byte, xdata_byte, wr_exp;

    task automatic clear_stats();
        cyc = 0; ale_cnt = 0; psen_lo = 0; rd_lo = 0; wr_lo = 0;
        overlap = 0; wr_bad = 0; fack_cnt = 0; mack_cnt = 0;
        fack_first = -1; mack_first = -1; fack_last = -1;
        ale_p0 = 8'h00; ale_p2 = 8'h00;
    endtask

    // One cycle: observe at the falling edge, act as a held-until-ack requester and as external memory.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (ale) begin
            ale_cnt++;
            ale_p0 = p0_out;
            ale_p2 = p2_out;
        end
        if (!psen_n) psen_lo++;
        if (!rd_n) rd_lo++;
        if (!wr_n) begin
            wr_lo++;
            if (p0_out !== wr_exp || p0_oe !== 1'b1) wr_bad++;
        end
        if (!({psen_n, rd_n, wr_n} inside {3'b111, 3'b011, 3'b101, 3'b110})) overlap++;
        if (fetch_ack) begin
            fack_cnt++;
            if (fack_first < 0) fack_first = cyc;
            fack_last = cyc;
            fetch_req = 1'b0;
        end
        if (movx_ack) begin
            mack_cnt++;
            if (mack_first < 0) mack_first = cyc;
            movx_req = 1'b0;
        end
        p0_in = !psen_n ? code_byte : (!rd_n ? xdata_byte : 8'h00);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        steps(2);
        n_cmp++; if (ale !== 1'b0) begin n_bad++; $display("FAIL reset_ale got %b want 0", ale); end
        n_cmp++; if ({psen_n, rd_n, wr_n} !== 3'b111) begin n_bad++; $display("FAIL reset_strobes got %b want 111", {psen_n, rd_n, wr_n}); end
        n_cmp++; if (p0_oe !== 1'b0) begin n_bad++; $display("FAIL reset_p0_oe got %b want 0", p0_oe); end
        n_cmp++; if ({p0_out, p2_out} !== 16'h0000) begin n_bad++; $display("FAIL reset_p0_p2 got %h want 0000", {p0_out, p2_out}); end
        n_cmp++; if ({fetch_ack, movx_ack, busy} !== 3'b000) begin n_bad++; $display("FAIL reset_ack_busy got %b want 000", {fetch_ack, movx_ack, busy}); end
        n_cmp++; if ({fetch_data, movx_rdata} !== 16'h0000) begin n_bad++; $display("FAIL reset_data got %h want 0000", {fetch_data, movx_rdata}); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_fetch_read();
        clear_stats();
        code_byte = 8'hA5;
        fetch_addr = 16'h1234;
        fetch_req = 1'b1;
        step();
        n_cmp++; if ({ale, p0_oe, busy} !== 3'b111) begin n_bad++; $display("FAIL fetch_addr_phase got %b want 111", {ale, p0_oe, busy}); end
        fetch_addr = 16'hFFFF;
        steps(9);
        n_cmp++; if (fack_first !== 5) begin n_bad++; $display("FAIL fetch_latency got %0d want 5", fack_first); end
        n_cmp++; if ({ale_p2, ale_p0} !== 16'h1234) begin n_bad++; $display("FAIL fetch_ale_addr got %h want 1234", {ale_p2, ale_p0}); end
        n_cmp++; if (ale_cnt !== 1) begin n_bad++; $display("FAIL fetch_ale_count got %0d want 1", ale_cnt); end
        n_cmp++; if (psen_lo !== 2 || rd_lo !== 0 || wr_lo !== 0) begin n_bad++; $display("FAIL fetch_strobes got psen %0d rd %0d wr %0d want 2 0 0", psen_lo, rd_lo, wr_lo); end
        n_cmp++; if (fetch_data !== 8'hA5) begin n_bad++; $display("FAIL fetch_data got %h want a5", fetch_data); end
        n_cmp++; if (fack_cnt !== 1 || busy !== 1'b0) begin n_bad++; $display("FAIL fetch_done got acks %0d busy %b want 1 0", fack_cnt, busy); end
        n_cmp++; if (p2_out !== 8'h12) begin n_bad++; $display("FAIL fetch_p2_hold got %h want 12", p2_out); end
    endtask

    task automatic test_movx_write();
        clear_stats();
        wr_exp = 8'h3C;
        movx_we = 1'b1;
        movx_addr = 16'h8001;
        movx_wdata = 8'h3C;
        movx_req = 1'b1;
        step();
        movx_wdata = 8'hFF;
        movx_addr = 16'h0000;
        movx_we = 1'b0;
        steps(4);
        n_cmp++; if ({movx_ack, wr_n, p0_oe, p0_out} !== {3'b111, 8'h3C}) begin n_bad++; $display("FAIL write_end_hold got %b %b %b %h want 1 1 1 3c", movx_ack, wr_n, p0_oe, p0_out); end
        steps(5);
        n_cmp++; if ({ale_p2, ale_p0} !== 16'h8001) begin n_bad++; $display("FAIL write_ale_addr got %h want 8001", {ale_p2, ale_p0}); end
        n_cmp++; if (wr_lo !== 2 || rd_lo !== 0 || psen_lo !== 0) begin n_bad++; $display("FAIL write_strobes got wr %0d rd %0d psen %0d want 2 0 0", wr_lo, rd_lo, psen_lo); end
        n_cmp++; if (wr_bad !== 0) begin n_bad++; $display("FAIL write_data_bad_cycles got %0d want 0", wr_bad); end
        n_cmp++; if (mack_cnt !== 1 || mack_first !== 5) begin n_bad++; $display("FAIL write_ack got count %0d at %0d want 1 at 5", mack_cnt, mack_first); end
        n_cmp++; if (p0_oe !== 1'b0) begin n_bad++; $display("FAIL write_idle_oe got %b want 0", p0_oe); end
    endtask

    task automatic test_contention();
        apply_reset();
        clear_stats();
        code_byte = 8'h11;
        xdata_byte = 8'h5A;
        fetch_addr = 16'h0010;
        movx_addr = 16'h4455;
        movx_we = 1'b0;
        fetch_req = 1'b1;
        movx_req = 1'b1;
        steps(13);
        n_cmp++; if (fack_first !== 5) begin n_bad++; $display("FAIL contend_fetch_first got %0d want 5", fack_first); end
        n_cmp++; if (mack_first !== 10) begin n_bad++; $display("FAIL contend_movx_second got %0d want 10", mack_first); end
        n_cmp++; if ({fetch_data, movx_rdata} !== 16'h115A) begin n_bad++; $display("FAIL contend_data got %h want 115a", {fetch_data, movx_rdata}); end
        n_cmp++; if (ale_cnt !== 2 || overlap !== 0) begin n_bad++; $display("FAIL contend_ale_overlap got %0d %0d want 2 0", ale_cnt, overlap); end
        n_cmp++; if ({ale_p2, ale_p0} !== 16'h4455) begin n_bad++; $display("FAIL contend_movx_addr got %h want 4455", {ale_p2, ale_p0}); end
    endtask

    task automatic test_reset_mid_access();
        clear_stats();
        xdata_byte = 8'h99;
        movx_we = 1'b0;
        movx_addr = 16'h2222;
        movx_req = 1'b1;
        steps(4);
        n_cmp++; if (rd_n !== 1'b0) begin n_bad++; $display("FAIL abort_in_strobe got rd_n %b want 0", rd_n); end
        reset = 1'b1;
        movx_req = 1'b0;
        step();
        n_cmp++; if ({rd_n, p0_oe, movx_ack, busy} !== 4'b1000) begin n_bad++; $display("FAIL abort_outputs got %b want 1000", {rd_n, p0_oe, movx_ack, busy}); end
        n_cmp++; if (movx_rdata !== 8'h00) begin n_bad++; $display("FAIL abort_rdata got %h want 00", movx_rdata); end
        reset = 1'b0;
        steps(6);
        n_cmp++; if (mack_cnt !== 0 || ale_cnt !== 1) begin n_bad++; $display("FAIL abort_no_ack got acks %0d ale %0d want 0 1", mack_cnt, ale_cnt); end
    endtask

    task automatic test_pulse_while_busy();
        clear_stats();
        code_byte = 8'h42;
        fetch_addr = 16'h00FF;
        fetch_req = 1'b1;
        steps(3);
        movx_req = 1'b1;
        movx_we = 1'b1;
        step();
        movx_req = 1'b0;
        steps(8);
        n_cmp++; if (mack_cnt !== 0 || wr_lo !== 0 || rd_lo !== 0) begin n_bad++; $display("FAIL pulse_ignored got acks %0d wr %0d rd %0d want 0 0 0", mack_cnt, wr_lo, rd_lo); end
        n_cmp++; if (fack_cnt !== 1 || ale_cnt !== 1 || fetch_data !== 8'h42) begin n_bad++; $display("FAIL pulse_fetch got acks %0d ale %0d data %h want 1 1 42", fack_cnt, ale_cnt, fetch_data); end
    endtask

    // Last grant was the fetch, so MOVX wins this contention.
    task automatic test_arb_alternate();
        clear_stats();
        code_byte = 8'h66;
        xdata_byte = 8'h77;
        fetch_addr = 16'h0100;
        movx_addr = 16'h0200;
        movx_we = 1'b0;
        fetch_req = 1'b1;
        movx_req = 1'b1;
        steps(13);
        n_cmp++; if (mack_first !== 5 || fack_first !== 10) begin n_bad++; $display("FAIL arb_order got movx %0d fetch %0d want 5 10", mack_first, fack_first); end
        n_cmp++; if ({fetch_data, movx_rdata} !== 16'h6677) begin n_bad++; $display("FAIL arb_data got %h want 6677", {fetch_data, movx_rdata}); end
    endtask

    task automatic test_back_to_back_same();
        clear_stats();
        code_byte = 8'h5C;
        fetch_addr = 16'h0001;
        fetch_req = 1'b1;
        steps(5);
        fetch_req = 1'b1;
        fetch_addr = 16'h0002;
        steps(9);
        n_cmp++; if (fack_cnt !== 2 || fack_last !== 11) begin n_bad++; $display("FAIL same_rerequest got acks %0d last %0d want 2 11", fack_cnt, fack_last); end
        n_cmp++; if (ale_p0 !== 8'h02 || ale_cnt !== 2) begin n_bad++; $display("FAIL same_second_addr got %h ale %0d want 02 2", ale_p0, ale_cnt); end
    endtask

`ifdef XBUS_WAIT_EN
    task automatic test_wait();
        clear_stats();
        code_byte = 8'hE7;
        fetch_addr = 16'h3000;
        wait_cycles = 2'd3;
        fetch_req = 1'b1;
        step();
        wait_cycles = 2'd0;
        steps(10);
        n_cmp++; if (psen_lo !== 5 || fack_first !== 8) begin n_bad++; $display("FAIL wait_stretch got psen %0d ack %0d want 5 8", psen_lo, fack_first); end
        n_cmp++; if (fetch_data !== 8'hE7) begin n_bad++; $display("FAIL wait_data got %h want e7", fetch_data); end
    endtask
`endif

    initial begin
        reset = 1'b1;
        fetch_req = 1'b0;
        fetch_addr = 16'h0000;
        movx_req = 1'b0;
        movx_we = 1'b0;
        movx_addr = 16'h0000;
        movx_wdata = 8'h00;
        p0_in = 8'h00;
        code_byte = 8'h00;
        xdata_byte = 8'h00;
        wr_exp = 8'h00;
`ifdef XBUS_WAIT_EN
        wait_cycles = 2'd0;
`endif
        clear_stats();
        test_reset();
        test_fetch_read();
        test_movx_write();
        test_contention();
        test_reset_mid_access();
        test_pulse_while_busy();
        test_arb_alternate();
        test_back_to_back_same();
`ifdef XBUS_WAIT_EN
        test_wait();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
